// File: rtl/tdm_demux4_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the 4-channel TDM receive demultiplexer.
//   NCH       : number of TDM channels per frame
//   slot_t    : 2-bit channel slot index
//   state_t   : slot FSM states; the encoding equals the slot number
//   ERR_CNT_W : width of the optional sync-error counter
//               (present when TDM_DEMUX_ERR_CNT_EN is defined)
// ----------------------------------------------------------------------------
package tdm_pkg;

    localparam int NCH       = 4;
    localparam int ERR_CNT_W = 8;

    typedef logic [1:0] slot_t;

    typedef enum logic [1:0] {
        ST_CH0 = 2'd0,
        ST_CH1 = 2'd1,
        ST_CH2 = 2'd2,
        ST_CH3 = 2'd3
    } state_t;

endpackage

// File: rtl/tdm_demux4_slot_counter.sv
// ----------------------------------------------------------------------------
// tdm_slot_counter
// Modulo-4 slot counter for the TDM demux. Advances on each enabled cycle,
// loads slot 1 when a start-of-frame word is accepted (that word takes slot 0).
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous reset, active-high (slot returns to 0)
//   en   in   accept strobe (din_valid)
//   sof  in   start of frame, qualified by en
//   s    out  slot the next accepted word is written to (registered)
//   wrap out  strobe: the word accepted this cycle completes a frame
// ----------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  sof,
    output slot_t s,
    output logic  wrap
);

    state_t r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CH0;
        end else if (en) begin
            if (sof) begin
                r_state <= ST_CH1;
            end else begin
                unique case (r_state)
                    ST_CH0:  r_state <= ST_CH1;
                    ST_CH1:  r_state <= ST_CH2;
                    ST_CH2:  r_state <= ST_CH3;
                    ST_CH3:  r_state <= ST_CH0;
                    default: r_state <= ST_CH0;
                endcase
            end
        end
    end

    assign s    = slot_t'(r_state);
    // Only a non-sof word landing in slot 3 closes a frame.
    assign wrap = en & ~sof & (r_state == ST_CH3);

endmodule

// File: rtl/tdm_demux4.sv
// ----------------------------------------------------------------------------
// tdm_demux4
// Receive side of a 4-channel TDM link. Each valid word is steered to slot
// 0..3 in rotation; after slot 3 the full frame is presented on w0..w3
// together with a one-cycle frame_valid pulse. A sof arriving mid-frame
// restarts at slot 0, drops the partial frame and pulses sync_err.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   din         in   incoming TDM word [WIDTH]
//   din_valid   in   din valid this cycle
//   sof         in   start of frame (din is channel 0), qualified by din_valid
//   w0..w3      out  channel words of last complete frame [WIDTH]
//   frame_valid out  one-cycle pulse when w0..w3 update
//   s           out  slot the next valid word is written to
//   sync_err    out  one-cycle pulse on frame misalignment
//   err_cnt     out  saturating sync_err count [ERR_CNT_W]
//                    (only when TDM_DEMUX_ERR_CNT_EN is defined)
// ----------------------------------------------------------------------------
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] w0,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3,
    output logic             frame_valid,
    output logic [1:0]       s,
    output logic             sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    slot_t w_s;
    logic  w_wrap;

    // Slot 3 is never stored: the closing word goes straight to w3.
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;

    tdm_slot_counter u_slot (
        .clk  (clk),
        .rst  (rst),
        .en   (din_valid),
        .sof  (sof),
        .s    (w_s),
        .wrap (w_wrap)
    );

    assign s = w_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            w3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    // Restart at channel 0; shadow 1..2 are left as-is.
                    r_sh0    <= din;
                    sync_err <= (w_s != ST_CH0);
                end else if (w_wrap) begin
                    w0          <= r_sh0;
                    w1          <= r_sh1;
                    w2          <= r_sh2;
                    w3          <= din;
                    frame_valid <= 1'b1;
                end else begin
                    unique case (w_s)
                        ST_CH0:  r_sh0 <= din;
                        ST_CH1:  r_sh1 <= din;
                        ST_CH2:  r_sh2 <= din;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (sync_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: expected frames are queued as words are
// driven and popped when frame_valid is seen.
// Optional err_cnt checks are enabled with TDM_DEMUX_ERR_CNT_EN.
module tb_tdm_demux4;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] w0, w1, w2, w3;
    logic             frame_valid;
    logic [1:0]       s;
    logic             sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_frames = 0;
    int unsigned n_sync   = 0;
    logic [11:0] exp_q[$];

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .w0          (w0),
        .w1          (w1),
        .w2          (w2),
        .w3          (w3),
        .frame_valid (frame_valid),
        .s           (s),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] frm(input int a, input int b, input int c, input int d);
        logic [2:0] x0, x1, x2, x3;
        x0 = 3'(a); x1 = 3'(b); x2 = 3'(c); x3 = 3'(d);
        return {x0, x1, x2, x3};
    endfunction

    // Output monitor: every frame_valid pops one expected frame.
    always @(posedge clk) begin
        #1;
        if (frame_valid) begin
            n_frames++;
            chk("fv_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("frame", {w0, w1, w2, w3}, exp_q.pop_front());
        end
        if (sync_err) n_sync++;
    end

    // One valid word; returns #1 after the edge that consumed it.
    task automatic send(input int d, input logic f);
        din       = 3'(d);
        sof       = f;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int unsigned f0;

        // Reset state
        do_reset(2);
        chk("rst_w", {w0, w1, w2, w3}, 32'd0);
        chk("rst_fv", frame_valid, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_se", sync_err, 32'd0);

        // Basic frame
        exp_q.push_back(frm(1, 2, 3, 4));
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0);
        chk("f1_nofv", frame_valid, 32'd0);
        send(4, 1'b0);
        chk("f1_fv", frame_valid, 32'd1);
        chk("f1_s", s, 32'd0);
        chk("f1_se", sync_err, 32'd0);
        idle();
        chk("f1_fv_pulse", frame_valid, 32'd0);
        chk("f1_hold", {w0, w1, w2, w3}, frm(1, 2, 3, 4));

        // Gapped input: slot holds across idle cycles
        exp_q.push_back(frm(1, 2, 3, 4));
        f0 = n_frames;
        send(1, 1'b1); idle(); chk("gap_s1", s, 32'd1);
        send(2, 1'b0); idle(); chk("gap_s2", s, 32'd2);
        send(3, 1'b0); idle(); chk("gap_s3", s, 32'd3);
        chk("gap_nofv", n_frames - f0, 32'd0);
        send(4, 1'b0);
        chk("gap_fv", frame_valid, 32'd1);
        idle();

        // Back-to-back frames, no bubble
        exp_q.push_back(frm(2, 3, 4, 5));
        exp_q.push_back(frm(3, 4, 5, 6));
        f0 = n_frames;
        send(2, 1'b1); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        chk("b2b_fv1", frame_valid, 32'd1);
        send(3, 1'b1); send(4, 1'b0); send(5, 1'b0);
        chk("b2b_gap_fv", frame_valid, 32'd0);
        send(6, 1'b0);
        chk("b2b_fv2", frame_valid, 32'd1);
        idle();
        chk("b2b_count", n_frames - f0, 32'd2);

        // Resync: sof in slot 2 drops partial frame
        exp_q.push_back(frm(2, 3, 4, 5));
        f0 = n_frames;
        send(7, 1'b1); send(1, 1'b0);
        chk("rs_se_pre", sync_err, 32'd0);
        send(2, 1'b1);
        chk("rs_se", sync_err, 32'd1);
        chk("rs_s", s, 32'd1);
        send(3, 1'b0);
        chk("rs_se_pulse", sync_err, 32'd0);
        send(4, 1'b0); send(5, 1'b0);
        idle();
        chk("rs_count", n_frames - f0, 32'd1);
        chk("rs_nsync", n_sync, 32'd1);

        // Reset mid-frame discards collected words
        f0 = n_frames;
        send(1, 1'b1); send(2, 1'b0);
        do_reset(1);
        chk("mr_w", {w0, w1, w2, w3}, 32'd0);
        chk("mr_s", s, 32'd0);
        exp_q.push_back(frm(4, 5, 6, 7));
        send(4, 1'b1); send(5, 1'b0); send(6, 1'b0); send(7, 1'b0);
        idle();
        chk("mr_count", n_frames - f0, 32'd1);
        chk("mr_nsync", n_sync, 32'd1);

`ifdef TDM_DEMUX_ERR_CNT_EN
        // Saturating error counter
        do_reset(1);
        chk("ec_rst", err_cnt, 32'd0);
        send(0, 1'b0);
        for (int i = 0; i < 300; i++) send(0, 1'b1);
        idle(); idle();
        chk("ec_sat", err_cnt, 32'd255);
        chk("ec_nsync", n_sync, 32'd301);
`endif

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
